// File: rtl/mfp_bus_master.sv
// Bus master for an MFP-style peripheral. It runs register accesses and interrupt-acknowledge
// cycles on a strobed bus, and every bus transition is paced by the clk_en tick.
module mfp_bus_master #(
  parameter int         TIMEOUT      = 15,
  parameter logic [7:0] SPURIOUS_VEC = 8'h18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  input  logic       irq_in,
  input  logic       irq_enable,
  output logic       vec_valid,
  output logic [7:0] vec,
  output logic       vec_err,
  output logic       bus_sel,
  output logic       bus_iack,
  output logic       bus_ds,
  output logic       bus_rw,
  output logic [4:0] bus_addr,
  output logic [7:0] bus_dout,
  input  logic [7:0] bus_din,
  input  logic       bus_dtack
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE, HOLDOFF} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          hcnt_q, hcnt_d;
  logic          iack_cyc_q, iack_cyc_d;
  logic          bus_sel_q, bus_sel_d;
  logic          bus_iack_q, bus_iack_d;
  logic          bus_ds_q, bus_ds_d;
  logic          bus_rw_q, bus_rw_d;
  logic [4:0]    bus_addr_q, bus_addr_d;
  logic [7:0]    bus_dout_q, bus_dout_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          vec_valid_q, vec_valid_d;
  logic [7:0]    vec_q, vec_d;
  logic          vec_err_q, vec_err_d;

  assign bus_sel   = bus_sel_q;
  assign bus_iack  = bus_iack_q;
  assign bus_ds    = bus_ds_q;
  assign bus_rw    = bus_rw_q;
  assign bus_addr  = bus_addr_q;
  assign bus_dout  = bus_dout_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign vec_valid = vec_valid_q;
  assign vec       = vec_q;
  assign vec_err   = vec_err_q;

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    hcnt_d      = hcnt_q;
    iack_cyc_d  = iack_cyc_q;
    bus_sel_d   = bus_sel_q;
    bus_iack_d  = bus_iack_q;
    bus_ds_d    = bus_ds_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    vec_valid_d = 1'b0;
    vec_d       = vec_q;
    vec_err_d   = vec_err_q;
    cmd_ready   = 1'b0;

    if (clk_en) begin
      case (state_q)
        IDLE: begin
          // The strobe goes out on the same tick as the select, so the cycle starts with the strobe active.
          if (irq_in && irq_enable) begin
            state_d    = ACTIVE;
            tcnt_d     = '0;
            iack_cyc_d = 1'b1;
            bus_iack_d = 1'b1;
            bus_ds_d   = 1'b0;
            bus_rw_d   = 1'b1;
          end else if (cmd_valid) begin
            cmd_ready  = !reset;
            state_d    = ACTIVE;
            tcnt_d     = '0;
            iack_cyc_d = 1'b0;
            bus_sel_d  = 1'b1;
            bus_ds_d   = 1'b0;
            bus_rw_d   = !cmd_we;
            bus_addr_d = cmd_addr;
            bus_dout_d = cmd_wdata;
          end
        end
        ACTIVE: begin
          if (bus_dtack || tcnt_q == TCNT_LAST) begin
            state_d    = RELEASE;
            tcnt_d     = '0;
            bus_sel_d  = 1'b0;
            bus_iack_d = 1'b0;
            bus_ds_d   = 1'b1;
            if (iack_cyc_q) begin
              vec_valid_d = 1'b1;
              vec_d       = bus_dtack ? bus_din : SPURIOUS_VEC;
              vec_err_d   = !bus_dtack;
            end else begin
              rsp_valid_d = 1'b1;
              rsp_rdata_d = (bus_dtack && bus_rw_q) ? bus_din : 8'h00;
              rsp_err_d   = !bus_dtack;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        RELEASE: begin
          hcnt_d  = 1'b0;
          state_d = iack_cyc_q ? HOLDOFF : IDLE;
        end
        HOLDOFF: begin
          // Give the peripheral two ticks to drop irq_in before a new arbitration.
          if (hcnt_q) begin
            hcnt_d  = 1'b0;
            state_d = IDLE;
          end else begin
            hcnt_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      hcnt_q      <= 1'b0;
      iack_cyc_q  <= 1'b0;
      bus_sel_q   <= 1'b0;
      bus_iack_q  <= 1'b0;
      bus_ds_q    <= 1'b1;
      bus_rw_q    <= 1'b1;
      bus_addr_q  <= 5'h00;
      bus_dout_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_q       <= 8'h00;
      vec_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      hcnt_q      <= hcnt_d;
      iack_cyc_q  <= iack_cyc_d;
      bus_sel_q   <= bus_sel_d;
      bus_iack_q  <= bus_iack_d;
      bus_ds_q    <= bus_ds_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      vec_valid_q <= vec_valid_d;
      vec_q       <= vec_d;
      vec_err_q   <= vec_err_d;
    end
  end

endmodule
